// File: rtl/hop_pipe_pkg.sv
// rtl/hop_pipe_pkg.sv - shared constants and helpers for hop_pipe_elastic.
package hop_pipe_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int POP_W         = 64;

  function automatic int popcount(input logic [POP_W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < POP_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  // Clamps a + b to the largest value representable in w bits.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int w);
    logic [63:0] max_v;
    logic [63:0] sum;
    max_v = (64'd1 << w) - 64'd1;
    sum   = a + b;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/hop_pipe_stage.sv
// rtl/hop_pipe_stage.sv - one elastic register stage with synchronous clear and drop flag.
module hop_pipe_stage
  import hop_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  input  logic             down_ready,
  input  logic             clr,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             drop
);

  logic incoming;
  logic outgoing;

  assign up_ready = !valid | down_ready;
  assign incoming = up_valid & up_ready;
  assign outgoing = valid & down_ready;
  // A held beat that is not leaving, or any beat arriving, dies under clear.
  assign drop     = clr & ((valid & !outgoing) | incoming);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (incoming) begin
      valid <= 1'b1;
      data  <= up_data;
    end else if (outgoing) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hop_pipe_elastic.sv
// rtl/hop_pipe_elastic.sv - DEPTH-stage elastic valid/ready pipeline with per-stage clears.
// HOP_PIPE_DROP_CNT_EN adds the saturating drop counter; otherwise drop_cnt is tied to 0.
module hop_pipe_elastic
  import hop_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                       clock0,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic [DEPTH-1:0]           stage_clr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH:0]   r;
  logic [DEPTH-1:0] uv;
  logic [WIDTH-1:0] ud [DEPTH];
  logic [DEPTH-1:0] drops;

  assign r[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign uv[i] = in_valid;
      assign ud[i] = in_data;
    end else begin : g_link
      assign uv[i] = v[i-1];
      assign ud[i] = d[i-1];
    end

    hop_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clock0),
      .rst_n      (rst_n),
      .up_valid   (uv[i]),
      .up_data    (ud[i]),
      .up_ready   (r[i]),
      .down_ready (r[i+1]),
      .clr        (stage_clr[i]),
      .valid      (v[i]),
      .data       (d[i]),
      .drop       (drops[i])
    );
  end

  assign in_ready  = r[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign occupancy = OCC_W'(popcount(POP_W'(v)));

`ifdef HOP_PIPE_DROP_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock0 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= CNT_W'(sat_add(64'(cnt_q), 64'(popcount(POP_W'(drops))), CNT_W));
    end
  end

  assign drop_cnt = cnt_q;
`else
  logic unused_drops;
  assign unused_drops = ^drops;
  assign drop_cnt     = '0;
`endif

endmodule
